// File: rtl/tone_period_decoder.sv
// Recovers a note-select divider code from the spacing between edges of a square-wave tone.
// Both edges count; a code is reported once MATCH_N consecutive half-periods agree.
module tone_period_decoder #(
    parameter int unsigned TOL     = 256,
    parameter int unsigned MATCH_N = 2,
    parameter logic [31:0] TIMEOUT = 32'h0001_0000
) (
    input  logic        inClk,
    input  logic        reset,
    input  logic        toneIn,
    output logic [2:0]  noteCode,
    output logic        noteValid,
    output logic [31:0] periodOut,
    output logic        periodStrobe
);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    localparam logic [31:0] NOM [8] = '{
        32'h0000_BABA, 32'h0000_A65E, 32'h0000_9431, 32'h0000_8BE9,
        32'h0000_7CB9, 32'h0000_6EFA, 32'h0000_62F2, 32'h0000_5D5E
    };
    localparam logic [2:0] MATCH_N3 = 3'(MATCH_N);

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  cand_q, cand_d;
    logic [2:0]  run_q, run_d;
    logic [2:0]  note_code_q, note_code_d;
    logic        note_valid_q, note_valid_d;
    logic [31:0] period_q, period_d;
    logic        strobe_q, strobe_d;

    logic        edge_det;
    logic        timeout;
    logic        hit;
    logic [2:0]  hit_code;
    logic [31:0] diff;
    logic [2:0]  cand_new;
    logic [2:0]  run_new;

    assign edge_det = sync2_q ^ prev_q;
    assign timeout  = (cnt_q == TIMEOUT) && !edge_det;

    // Absolute distance to each nominal; the table gaps guarantee at most one hit.
    always_comb begin
        hit      = 1'b0;
        hit_code = 3'd0;
        diff     = '0;
        for (int k = 0; k < 8; k++) begin
            diff = (cnt_q >= NOM[k]) ? (cnt_q - NOM[k]) : (NOM[k] - cnt_q);
            if (diff <= TOL) begin
                hit      = 1'b1;
                hit_code = 3'(k);
            end
        end
    end

    always_comb begin
        cand_new = cand_q;
        run_new  = 3'd0;
        if (hit && (run_q != 3'd0) && (hit_code == cand_q)) begin
            run_new = (run_q == 3'd7) ? run_q : run_q + 3'd1;
        end else if (hit) begin
            cand_new = hit_code;
            run_new  = 3'd1;
        end
    end

    always_comb begin
        sync1_d      = toneIn;
        sync2_d      = sync1_q;
        prev_d       = sync2_q;
        cnt_d        = edge_det ? 32'd1 : ((cnt_q == TIMEOUT) ? cnt_q : cnt_q + 32'd1);
        state_d      = state_q;
        cand_d       = cand_q;
        run_d        = run_q;
        note_code_d  = note_code_q;
        note_valid_d = note_valid_q;
        period_d     = period_q;
        strobe_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (edge_det) state_d = MEASURE;
            end
            MEASURE: begin
                if (edge_det) begin
                    strobe_d = 1'b1;
                    period_d = cnt_q;
                    cand_d   = cand_new;
                    run_d    = run_new;
                    if (run_new >= MATCH_N3) begin
                        note_code_d  = cand_new;
                        note_valid_d = 1'b1;
                        state_d      = LOCKED;
                    end
                end else if (timeout) begin
                    note_valid_d = 1'b0;
                    run_d        = 3'd0;
                    state_d      = IDLE;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    strobe_d = 1'b1;
                    period_d = cnt_q;
                    if (!(hit && (hit_code == note_code_q))) begin
                        note_valid_d = 1'b0;
                        cand_d       = cand_new;
                        run_d        = run_new;
                        state_d      = MEASURE;
                    end
                end else if (timeout) begin
                    note_valid_d = 1'b0;
                    run_d        = 3'd0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge inClk) begin
        if (reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            cand_q       <= '0;
            run_q        <= '0;
            note_code_q  <= '0;
            note_valid_q <= 1'b0;
            period_q     <= '0;
            strobe_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            cand_q       <= cand_d;
            run_q        <= run_d;
            note_code_q  <= note_code_d;
            note_valid_q <= note_valid_d;
            period_q     <= period_d;
            strobe_q     <= strobe_d;
        end
    end

    assign noteCode     = note_code_q;
    assign noteValid    = note_valid_q;
    assign periodOut    = period_q;
    assign periodStrobe = strobe_q;

endmodule

// File: tb/tb_tone_period_decoder.sv
// Directed bench for tone_period_decoder: tone tables, tolerance edges, timeout, reset and glitches.
module tb_tone_period_decoder;

    localparam logic [31:0] TIMEOUT = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        tone_in;
    logic [2:0]  note_code;
    logic        note_valid;
    logic [31:0] period_out;
    logic        period_strobe;

    tone_period_decoder #(
        .TOL    (256),
        .MATCH_N(2),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .inClk       (clk),
        .reset       (reset),
        .toneIn      (tone_in),
        .noteCode    (note_code),
        .noteValid   (note_valid),
        .periodOut   (period_out),
        .periodStrobe(period_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          h;
        bit          strobe;
        logic [31:0] p;
        logic [2:0]  code;
        logic        valid;
    } vec_t;

    typedef struct packed {
        logic [31:0] p;
        logic [2:0]  code;
        logic        valid;
    } obs_t;

    obs_t        got_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;
    longint      last_strobe_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (period_strobe === 1'b1) begin
            got_q.push_back('{p: period_out, code: note_code, valid: note_valid});
            last_strobe_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Toggles the tone h clocks after the previous toggle, then checks the strobe it caused.
    task automatic step(input vec_t v);
        obs_t o;
        repeat (v.h - 6) @(negedge clk);
        tone_in = ~tone_in;
        repeat (6) @(negedge clk);
        chk("strobe_count", got_q.size(), {31'd0, v.strobe});
        if (v.strobe && got_q.size() == 1) begin
            o = got_q[0];
            chk("periodOut", o.p, v.p);
            chk("noteCode", {29'd0, o.code}, {29'd0, v.code});
            chk("noteValid", {31'd0, o.valid}, {31'd0, v.valid});
        end
        got_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_code"}, {29'd0, note_code}, 32'd0);
        chk({tag, "_valid"}, {31'd0, note_valid}, 32'd0);
        chk({tag, "_period"}, period_out, 32'd0);
        chk({tag, "_strobe"}, {31'd0, period_strobe}, 32'd0);
    endtask

    initial begin
        vec_t tbl[12];
        obs_t o;
        int   w;

        tbl[0]  = '{6,       1'b0, 32'h0,    3'd0, 1'b0};
        tbl[1]  = '{'hBABA,  1'b1, 32'hBABA, 3'd0, 1'b0};
        tbl[2]  = '{'hBABA,  1'b1, 32'hBABA, 3'd0, 1'b1};
        tbl[3]  = '{'h5D5E,  1'b1, 32'h5D5E, 3'd0, 1'b0};
        tbl[4]  = '{'h5D5E,  1'b1, 32'h5D5E, 3'd7, 1'b1};
        tbl[5]  = '{'h9531,  1'b1, 32'h9531, 3'd7, 1'b0};
        tbl[6]  = '{'h9531,  1'b1, 32'h9531, 3'd2, 1'b1};
        tbl[7]  = '{'h9532,  1'b1, 32'h9532, 3'd2, 1'b0};
        tbl[8]  = '{'h9331,  1'b1, 32'h9331, 3'd2, 1'b0};
        tbl[9]  = '{'h9331,  1'b1, 32'h9331, 3'd2, 1'b1};
        tbl[10] = '{'h8BE9,  1'b1, 32'h8BE9, 3'd2, 1'b0};
        tbl[11] = '{'h8BE9,  1'b1, 32'h8BE9, 3'd3, 1'b1};

        tone_in = 1'b0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 12; i++) step(tbl[i]);

        // Hold the tone: lock must drop TIMEOUT clocks after the last strobe.
        w = 0;
        while (note_valid === 1'b1 && w < int'(TIMEOUT) + 100) begin
            @(negedge clk);
            w++;
        end
        chk("timeout_valid", {31'd0, note_valid}, 32'd0);
        chk("timeout_delay", 32'(cyc - last_strobe_cyc), TIMEOUT);
        chk("timeout_no_strobe", got_q.size(), 32'd0);
        chk("timeout_code_hold", {29'd0, note_code}, 32'd3);
        got_q.delete();

        step('{6,      1'b0, 32'h0,    3'd0, 1'b0});
        step('{'h6EFA, 1'b1, 32'h6EFA, 3'd3, 1'b0});
        step('{'h6EFA, 1'b1, 32'h6EFA, 3'd5, 1'b1});

        // One-cycle reset while locked.
        @(negedge clk);
        reset   = 1'b1;
        tone_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_outputs("midreset");
        got_q.delete();

        step('{6,      1'b0, 32'h0,    3'd0, 1'b0});
        step('{'h6EFA, 1'b1, 32'h6EFA, 3'd0, 1'b0});
        step('{'h6EFA, 1'b1, 32'h6EFA, 3'd5, 1'b1});

        step('{'h7CB9, 1'b1, 32'h7CB9, 3'd5, 1'b0});
        step('{'h7CB9, 1'b1, 32'h7CB9, 3'd4, 1'b1});

        // Glitch pair 15000 clocks into a half-period.
        repeat (15000 - 6) @(negedge clk);
        tone_in = ~tone_in;
        @(negedge clk);
        tone_in = ~tone_in;
        repeat (6) @(negedge clk);
        exp_q.push_back(32'd15000);
        exp_q.push_back(32'd1);
        chk("glitch_strobes", got_q.size(), 32'd2);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            o = got_q.pop_front();
            chk("glitch_period", o.p, exp_q.pop_front());
            chk("glitch_valid", {31'd0, o.valid}, 32'd0);
            chk("glitch_code", {29'd0, o.code}, 32'd4);
        end
        got_q.delete();
        exp_q.delete();

        step('{'h7CB9 - 15001, 1'b1, 32'h7CB9 - 32'd15001, 3'd4, 1'b0});
        step('{'h7CB9, 1'b1, 32'h7CB9, 3'd4, 1'b0});
        step('{'h7CB9, 1'b1, 32'h7CB9, 3'd4, 1'b1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
